crc_lut_engine: RTL and testbench

// - Byte-serial CRC-32 update engine that drives the 256-entry CRC lookup table and consumes its data.
// - Accepts 32-bit words on a valid/ready stream and folds 1-4 bytes per word into a running CRC, one byte per clock.
// - Framing uses sof/eof. On eof it presents the finalised CRC on an output valid/ready port.
// - Sits between the packet datapath and the CRC table ROM, which has a combinational read.

---
 rtl/crc_pkg.sv | 14 +
 rtl/crc_lut_engine_if.sv | 26 ++
 rtl/crc_byte_step.sv | 13 +
 rtl/crc_lut_engine.sv | 113 +++++++++++
 tb/tb_crc_lut_engine.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared widths, CRC word type and engine state encoding
package crc_pkg;
    localparam int CRC_W     = 32;
    localparam int BYTE_W    = 8;
    localparam int TAB_ABITS = 8;

    typedef logic [CRC_W-1:0] crc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } crc_state_t;
endpackage

// File: rtl/crc_lut_engine_if.sv
// rtl/crc_lut_engine_if.sv - word input stream, table port and result port of the CRC engine
interface crc_lut_engine_if;
    import crc_pkg::*;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [2:0]  s_nbytes;
    logic        s_sof;
    logic        s_eof;
    crc_t        tab_addr;
    crc_t        tab_rdata;
    logic        m_valid;
    logic        m_ready;
    crc_t        m_crc;

    modport master (
        output s_valid, s_data, s_nbytes, s_sof, s_eof, tab_rdata, m_ready,
        input  s_ready, tab_addr, m_valid, m_crc
    );

    modport slave (
        input  s_valid, s_data, s_nbytes, s_sof, s_eof, tab_rdata, m_ready,
        output s_ready, tab_addr, m_valid, m_crc
    );
endinterface

// File: rtl/crc_byte_step.sv
// rtl/crc_byte_step.sv - one table-driven CRC-32 byte update (MSB-first, combinational)
module crc_byte_step
    import crc_pkg::*;
(
    input  crc_t              crc_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  crc_t              tab_rdata_i,
    output crc_t              tab_addr_o,
    output crc_t              next_crc_o
);
    assign tab_addr_o = {{(CRC_W-TAB_ABITS){1'b0}}, crc_i[CRC_W-1 -: BYTE_W] ^ byte_i};
    assign next_crc_o = {crc_i[CRC_W-BYTE_W-1:0], {BYTE_W{1'b0}}} ^ tab_rdata_i;
endmodule

// File: rtl/crc_lut_engine.sv
// rtl/crc_lut_engine.sv - byte-serial CRC-32 engine folding 1-4 bytes per word via an external table
module crc_lut_engine
    import crc_pkg::*;
#(
    parameter crc_t CRC_INIT   = 32'h0000_0000,
    parameter crc_t CRC_XOROUT = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    crc_lut_engine_if.slave  bus
);
    crc_state_t        state_q, state_d;
    crc_t              crc_q, crc_d;
    logic [31:0]       data_q, data_d;
    logic [2:0]        nb_q, nb_d;
    logic [1:0]        idx_q, idx_d;
    logic              eof_q, eof_d;

    logic [BYTE_W-1:0] cur_byte;
    logic [2:0]        nb_in;
    logic              last_byte;
    logic              accept;
    crc_t              step_addr;
    crc_t              step_crc;

    always_comb begin
        cur_byte = data_q[31:24];
        case (idx_q)
            2'd0: cur_byte = data_q[31:24];
            2'd1: cur_byte = data_q[23:16];
            2'd2: cur_byte = data_q[15:8];
            2'd3: cur_byte = data_q[7:0];
            default: cur_byte = data_q[31:24];
        endcase
    end

    crc_byte_step u_step (
        .crc_i       (crc_q),
        .byte_i      (cur_byte),
        .tab_rdata_i (bus.tab_rdata),
        .tab_addr_o  (step_addr),
        .next_crc_o  (step_crc)
    );

    assign nb_in     = (bus.s_nbytes > 3'd4) ? 3'd4 : bus.s_nbytes;
    // nb_q is 1..4 in BUSY; a count of 4 wraps to 0 in two bits, so minus one lands on index 3.
    assign last_byte = (idx_q == (nb_q[1:0] - 2'd1));

    assign bus.s_ready  = (state_q == IDLE) && !rst;
    assign accept       = bus.s_valid && bus.s_ready;
    assign bus.m_valid  = (state_q == DONE);
    assign bus.m_crc    = (state_q == DONE) ? (crc_q ^ CRC_XOROUT) : '0;
    assign bus.tab_addr = (state_q == BUSY) ? step_addr : '0;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        data_d  = data_q;
        nb_d    = nb_q;
        idx_d   = idx_q;
        eof_d   = eof_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d = bus.s_data;
                    nb_d   = nb_in;
                    eof_d  = bus.s_eof;
                    idx_d  = 2'd0;
                    if (bus.s_sof) begin
                        crc_d = CRC_INIT;
                    end
                    if (nb_in != 3'd0) begin
                        state_d = BUSY;
                    end else if (bus.s_eof) begin
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                crc_d = step_crc;
                idx_d = idx_q + 2'd1;
                if (last_byte) begin
                    state_d = eof_q ? DONE : IDLE;
                end
            end
            DONE: begin
                if (bus.m_ready) begin
                    crc_d   = CRC_INIT;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            data_q  <= '0;
            nb_q    <= '0;
            idx_q   <= '0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            nb_q    <= nb_d;
            idx_q   <= idx_d;
            eof_q   <= eof_d;
        end
    end
endmodule

// File: tb/tb_crc_lut_engine.sv
// tb/tb_crc_lut_engine.sv - scoreboard bench for crc_lut_engine with a modelled lookup table
module tb_crc_lut_engine;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_q[$];

    crc_lut_engine_if bus ();

    crc_lut_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tab(input logic [7:0] i);
        case (i)
            8'h01:   tab = 32'h07F6E306;
            8'h07:   tab = 32'h17C0A912;
            8'h80:   tab = 32'hF632A5D9;
            default: tab = {i, ~i, i ^ 8'h5A, 8'hC3};
        endcase
    endfunction

    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] w, input int n);
        logic [31:0] r;
        logic [7:0]  b;
        r = c;
        for (int k = 0; k < n; k++) begin
            b = w[31-8*k -: 8];
            r = {r[23:0], 8'h00} ^ tab(r[31:24] ^ b);
        end
        return r;
    endfunction

    assign bus.tab_rdata = tab(bus.tab_addr[7:0]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] data, input logic [2:0] nb, input logic sof,
                        input logic eof, input logic push, input logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        bus.s_valid  = 1'b1;
        bus.s_data   = data;
        bus.s_nbytes = nb;
        bus.s_sof    = sof;
        bus.s_eof    = eof;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (push) exp_q.push_back(exp);
        if (ok) @(posedge clk);
        check("s_ready_timeout", {31'd0, ok}, 32'd1);
        #1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_eof   = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_m_crc: got %h expected no output", bus.m_crc);
                end else begin
                    check("m_crc", bus.m_crc, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.s_nbytes = '0;
        bus.s_sof    = 1'b0;
        bus.s_eof    = 1'b0;
        bus.m_ready  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("rst_m_crc", bus.m_crc, 32'd0);
        check("rst_tab_addr", bus.tab_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", {31'd0, bus.s_ready}, 32'd1);

        // Test 1 with latency, then test 4 backpressure on the same result
        send(32'h01AB_CDEF, 3'd1, 1'b1, 1'b1, 1'b1, 32'h07F6E306);
        @(negedge clk);
        check("t1_m_valid_early", {31'd0, bus.m_valid}, 32'd0);
        @(negedge clk);
        check("t1_m_valid_at_t2", {31'd0, bus.m_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_m_valid", {31'd0, bus.m_valid}, 32'd1);
            check("bp_m_crc", bus.m_crc, 32'h07F6E306);
            check("bp_s_ready", {31'd0, bus.s_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("bp_release_s_ready", {31'd0, bus.s_ready}, 32'd1);

        // Test 2: two bytes, table address sequence
        send(32'h0100_ABCD, 3'd2, 1'b1, 1'b1, 1'b1, 32'hE123AF12);
        @(negedge clk);
        check("t2_tab_addr0", bus.tab_addr, 32'h0000_0001);
        @(negedge clk);
        check("t2_tab_addr1", bus.tab_addr, 32'h0000_0007);

        // Test 3: one-byte word then an empty eof word
        send(32'h8012_3456, 3'd1, 1'b1, 1'b0, 1'b0, 32'd0);
        send(32'h0011_2233, 3'd0, 1'b0, 1'b1, 1'b1, 32'hF632A5D9);

        // Test 5: open frame abandoned by a new sof
        send(32'hA55A_1234, 3'd2, 1'b1, 1'b0, 1'b0, 32'd0);
        send(32'h0199_8877, 3'd1, 1'b1, 1'b1, 1'b1, 32'h07F6E306);

        // Reset while BUSY discards the frame
        send(32'hDEAD_BEEF, 3'd4, 1'b1, 1'b1, 1'b0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("rst_busy_s_ready", {31'd0, bus.s_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_idle_s_ready", {31'd0, bus.s_ready}, 32'd1);
        check("rst_busy_idle_tab_addr", bus.tab_addr, 32'd0);

        // Test 6: nbytes=7 clamps to 4 bytes
        send(32'h0100_0000, 3'd7, 1'b1, 1'b1, 1'b1, ref_crc(32'd0, 32'h0100_0000, 4));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_busy_m_valid", {31'd0, bus.m_valid}, 32'd0);
        end
        @(negedge clk);
        check("t6_m_valid", {31'd0, bus.m_valid}, 32'd1);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
